// File: rtl/aap_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encodings,
// default address width and the position of the 32-bit instruction marker.
package aap_fetch_pkg;

  // Default width of an instruction-word address.
  localparam int unsigned PC_WIDTH_DEFAULT = 16;

  // Bit of the first instruction word that marks a 32-bit instruction.
  localparam int unsigned IS32_BIT = 15;

  // Fetch sequencer states.
  //   S_FIRST  : waiting for the first word of an instruction
  //   S_SECOND : waiting for the second word of a 32-bit instruction
  //   S_HOLD   : complete instruction presented to the decoder
  typedef enum logic [1:0] {
    S_FIRST  = 2'd0,
    S_SECOND = 2'd1,
    S_HOLD   = 2'd2
  } fetch_state_e;

  // True when a first word announces a two-word instruction.
  function automatic logic is_32bit(input logic [15:0] word);
    return word[IS32_BIT];
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues one 16-bit word request at a time, assembles
// 16- or 32-bit instructions and hands them to the decoder.
//
// Handshake to the decoder: fetch_valid high means fetchoutput, fetch_is32
// and fetch_pc hold a complete instruction and stay stable until the cycle
// in which fetch_ready is also high; that cycle transfers the instruction.
//
// Memory side: imem_req/imem_addr stay asserted and constant until the
// memory answers with imem_valid (same cycle allowed). Only one request is
// ever outstanding. A redirect while a request is in flight leaves its
// response to be dropped before the new address is requested.
module instruction_fetch
  import aap_fetch_pkg::*;
#(
  parameter int unsigned           PC_WIDTH = PC_WIDTH_DEFAULT,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset_n,
  // instruction memory
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_valid,
  input  logic [15:0]         imem_rdata,
  // redirect
  input  logic                branch_valid,
  input  logic [PC_WIDTH-1:0] branch_target,
  // decoder
  output logic [31:0]         fetchoutput,
  output logic                fetch_is32,
  output logic [PC_WIDTH-1:0] fetch_pc,
  output logic                fetch_valid,
  input  logic                fetch_ready,
  // sequencer state, for observation
  output fetch_state_e        dbg_state
);

  fetch_state_e        state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_inc;
  logic                discard_q;
  logic                req_q;
  logic                valid_q;
  logic                is32_q;
  logic [31:0]         data_q;
  logic [PC_WIDTH-1:0] fetch_pc_q;

  // Next sequential word address; wraps from all-ones to zero.
  assign pc_inc = pc_q + PC_WIDTH'(1);

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign fetchoutput = data_q;
  assign fetch_is32  = is32_q;
  assign fetch_pc    = fetch_pc_q;
  assign fetch_valid = valid_q;
  assign dbg_state   = state_q;

  // Fetch sequencer: redirect first, then pending discard, then normal flow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_FIRST;
      pc_q       <= RESET_PC;
      discard_q  <= 1'b0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      is32_q     <= 1'b0;
      data_q     <= '0;
      fetch_pc_q <= '0;
    end else if (branch_valid) begin
      // A handshake in this cycle has already completed on the decoder side;
      // any partially assembled instruction is simply abandoned.
      pc_q    <= branch_target;
      state_q <= S_FIRST;
      valid_q <= 1'b0;
      if (discard_q) begin
        // Still owed a stale response: keep waiting unless it is here now.
        if (imem_valid) begin
          discard_q <= 1'b0;
          req_q     <= 1'b1;
        end else begin
          req_q     <= 1'b0;
        end
      end else if (req_q && !imem_valid) begin
        // Request in flight: its answer must be thrown away.
        discard_q <= 1'b1;
        req_q     <= 1'b0;
      end else begin
        // Nothing in flight (or it answered this cycle and is dropped).
        req_q <= 1'b1;
      end
    end else if (discard_q) begin
      // Drop the stale response, request the redirect target next cycle.
      if (imem_valid) begin
        discard_q <= 1'b0;
        req_q     <= 1'b1;
      end
    end else begin
      case (state_q)
        S_FIRST: begin
          if (!req_q) begin
            // First cycle out of reset: start requesting, ignore responses.
            req_q <= 1'b1;
          end else if (imem_valid) begin
            data_q[15:0] <= imem_rdata;
            fetch_pc_q   <= pc_q;
            pc_q         <= pc_inc;
            is32_q       <= 1'b0;
            if (is_32bit(imem_rdata)) begin
              // Keep requesting; address moves to the second word.
              state_q <= S_SECOND;
            end else begin
              data_q[31:16] <= '0;
              state_q       <= S_HOLD;
              req_q         <= 1'b0;
              valid_q       <= 1'b1;
            end
          end
        end
        S_SECOND: begin
          if (imem_valid) begin
            data_q[31:16] <= imem_rdata;
            is32_q        <= 1'b1;
            pc_q          <= pc_inc;
            state_q       <= S_HOLD;
            req_q         <= 1'b0;
            valid_q       <= 1'b1;
          end
        end
        S_HOLD: begin
          if (fetch_ready) begin
            state_q <= S_FIRST;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= S_FIRST;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed sequences with a behavioural memory,
// expected instructions queued at stimulus time and checked by monitors.
module tb_instruction_fetch;
  import aap_fetch_pkg::*;

  localparam int W = 49; // {is32, pc[15:0], instr[31:0]}

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- DUT 0 (RESET_PC = 0) ----------------
  logic        reset_n0;
  logic        imem_req0;
  logic [15:0] imem_addr0;
  logic        imem_valid0;
  logic [15:0] imem_rdata0;
  logic        branch_valid0;
  logic [15:0] branch_target0;
  logic [31:0] fetchoutput0;
  logic        fetch_is32_0;
  logic [15:0] fetch_pc0;
  logic        fetch_valid0;
  logic        fetch_ready0;
  fetch_state_e dbg_state0;

  instruction_fetch #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut0 (
    .clock(clock), .reset_n(reset_n0),
    .imem_req(imem_req0), .imem_addr(imem_addr0),
    .imem_valid(imem_valid0), .imem_rdata(imem_rdata0),
    .branch_valid(branch_valid0), .branch_target(branch_target0),
    .fetchoutput(fetchoutput0), .fetch_is32(fetch_is32_0), .fetch_pc(fetch_pc0),
    .fetch_valid(fetch_valid0), .fetch_ready(fetch_ready0),
    .dbg_state(dbg_state0)
  );

  // ---------------- DUT 1 (RESET_PC = 0xFFFF) ----------------
  logic        reset_n1;
  logic        imem_req1;
  logic [15:0] imem_addr1;
  logic        imem_valid1;
  logic [15:0] imem_rdata1;
  logic [31:0] fetchoutput1;
  logic        fetch_is32_1;
  logic [15:0] fetch_pc1;
  logic        fetch_valid1;
  logic        fetch_ready1;
  fetch_state_e dbg_state1;

  instruction_fetch #(.PC_WIDTH(16), .RESET_PC(16'hFFFF)) dut1 (
    .clock(clock), .reset_n(reset_n1),
    .imem_req(imem_req1), .imem_addr(imem_addr1),
    .imem_valid(imem_valid1), .imem_rdata(imem_rdata1),
    .branch_valid(1'b0), .branch_target(16'h0000),
    .fetchoutput(fetchoutput1), .fetch_is32(fetch_is32_1), .fetch_pc(fetch_pc1),
    .fetch_valid(fetch_valid1), .fetch_ready(fetch_ready1),
    .dbg_state(dbg_state1)
  );

  // ---------------- memory model ----------------
  logic [15:0] mem [0:65535];
  logic        mem_en0 = 1'b0;
  logic        mem_en1 = 1'b0;
  logic        stray0  = 1'b0;
  int          lat0    = 0;
  logic        pend0   = 1'b0;
  logic [15:0] paddr0  = '0;
  int          cnt0    = 0;

  // Zero latency answers combinationally; otherwise a captured request
  // answers lat0 cycles later, even if the requester has withdrawn.
  always_comb begin
    if (stray0) begin
      imem_valid0 = 1'b1;
      imem_rdata0 = 16'h8FFF;
    end else if (lat0 == 0) begin
      imem_valid0 = mem_en0 & imem_req0;
      imem_rdata0 = mem[imem_addr0];
    end else begin
      imem_valid0 = pend0 && (cnt0 == 0);
      imem_rdata0 = mem[paddr0];
    end
  end

  always @(posedge clock) begin
    if (!reset_n0) begin
      pend0 <= 1'b0;
    end else if (lat0 != 0) begin
      if (pend0) begin
        if (cnt0 == 0) pend0 <= 1'b0;
        else           cnt0  <= cnt0 - 1;
      end else if (imem_req0 && mem_en0) begin
        pend0  <= 1'b1;
        paddr0 <= imem_addr0;
        cnt0   <= lat0 - 1;
      end
    end
  end

  assign imem_valid1 = mem_en1 & imem_req1;
  assign imem_rdata1 = mem[imem_addr1];

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_e0;
  logic [W-1:0] exp_e1;
  int out_cnt0 = 0;
  int out_cnt1 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n0 && fetch_valid0 && fetch_ready0) begin
      if (exp_q0.size() == 0) begin
        chk("out0_unexpected", {fetch_is32_0, fetch_pc0, fetchoutput0}, 64'hDEAD_0000_0000_0000);
      end else begin
        exp_e0 = exp_q0.pop_front();
        chk("out0", {fetch_is32_0, fetch_pc0, fetchoutput0}, exp_e0);
      end
      out_cnt0++;
    end
  end

  always @(negedge clock) begin
    if (reset_n1 && fetch_valid1 && fetch_ready1) begin
      if (exp_q1.size() == 0) begin
        chk("out1_unexpected", {fetch_is32_1, fetch_pc1, fetchoutput1}, 64'hDEAD_0000_0000_0000);
      end else begin
        exp_e1 = exp_q1.pop_front();
        chk("out1", {fetch_is32_1, fetch_pc1, fetchoutput1}, exp_e1);
      end
      out_cnt1++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset0();
    reset_n0      = 1'b0;
    mem_en0       = 1'b0;
    stray0        = 1'b0;
    branch_valid0 = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n0 = 1'b1;
  endtask

  task automatic wait_out0(input int target);
    int n = 0;
    while (out_cnt0 < target && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    chk("wait_out0", (out_cnt0 >= target), 1);
  endtask

  // kind 0: fetch_valid0, 1: imem_req0, 2: state S_SECOND
  task automatic wait_sig0(input int kind);
    int n = 0;
    logic hit;
    hit = 1'b0;
    while (!hit && n < 200) begin
      @(posedge clock); #1;
      n++;
      case (kind)
        0:       hit = fetch_valid0;
        1:       hit = imem_req0;
        default: hit = (dbg_state0 == S_SECOND);
      endcase
    end
    chk("wait_sig0", hit, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    reset_n0 = 1'b0; reset_n1 = 1'b0;
    branch_valid0 = 1'b0; branch_target0 = 16'h0000;
    fetch_ready0 = 1'b1; fetch_ready1 = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;

    // Reset values
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_req",    imem_req0, 0);
    chk("rst_valid",  fetch_valid0, 0);
    chk("rst_out",    fetchoutput0, 0);
    chk("rst_is32",   fetch_is32_0, 0);
    chk("rst_pc",     fetch_pc0, 0);
    chk("rst_addr",   imem_addr0, 16'h0000);
    chk("rst_state",  dbg_state0, S_FIRST);
    chk("rst1_addr",  imem_addr1, 16'hFFFF);
    chk("rst1_pc",    fetch_pc1, 0);
    @(posedge clock); #1 reset_n0 = 1'b1;
    @(negedge clock);
    chk("req_after_release", imem_req0, 0);
    @(negedge clock);
    chk("req_first_edge", imem_req0, 1);

    // Two 16-bit instructions, zero latency
    mem[0] = 16'h020A; mem[1] = 16'h1234;
    exp_q0.push_back({1'b0, 16'h0000, 32'h0000_020A});
    exp_q0.push_back({1'b0, 16'h0001, 32'h0000_1234});
    base = out_cnt0;
    @(posedge clock); #1 mem_en0 = 1'b1;
    wait_out0(base + 2);
    mem_en0 = 1'b0;
    @(negedge clock);
    chk("t16_next_addr", imem_addr0, 16'h0002);
    chk("t16_next_req",  imem_req0, 1);

    // One 32-bit instruction
    mem[0] = 16'h8001; mem[1] = 16'h8ABC;
    do_reset0();
    exp_q0.push_back({1'b1, 16'h0000, 32'h8ABC_8001});
    base = out_cnt0;
    mem_en0 = 1'b1;
    wait_out0(base + 1);
    mem_en0 = 1'b0;
    @(negedge clock);
    chk("t32_next_addr", imem_addr0, 16'h0002);

    // Decoder stall holds everything
    mem[0] = 16'h020A; mem[1] = 16'h8ABC;
    do_reset0();
    fetch_ready0 = 1'b0;
    mem_en0 = 1'b1;
    wait_sig0(0);
    mem_en0 = 1'b0;
    repeat (5) begin
      @(negedge clock);
      chk("stall_valid", fetch_valid0, 1);
      chk("stall_out",   fetchoutput0, 32'h0000_020A);
      chk("stall_pc",    fetch_pc0, 16'h0000);
      chk("stall_is32",  fetch_is32_0, 0);
      chk("stall_req",   imem_req0, 0);
      chk("stall_addr",  imem_addr0, 16'h0001);
    end
    exp_q0.push_back({1'b0, 16'h0000, 32'h0000_020A});
    base = out_cnt0;
    @(posedge clock); #1 fetch_ready0 = 1'b1;
    wait_out0(base + 1);

    // Redirect while second word outstanding (latency 2)
    lat0 = 2;
    mem[0] = 16'h8001; mem[1] = 16'h8ABC; mem[16'h0040] = 16'h1234;
    do_reset0();
    exp_q0.push_back({1'b0, 16'h0040, 32'h0000_1234});
    base = out_cnt0;
    mem_en0 = 1'b1;
    wait_sig0(2);
    branch_valid0 = 1'b1; branch_target0 = 16'h0040;
    @(posedge clock); #1 branch_valid0 = 1'b0;
    @(negedge clock);
    chk("br_req_dropped", imem_req0, 0);
    chk("br_valid",       fetch_valid0, 0);
    chk("br_state",       dbg_state0, S_FIRST);
    wait_sig0(1);
    chk("br_new_addr",    imem_addr0, 16'h0040);
    wait_out0(base + 1);
    mem_en0 = 1'b0;

    // Reset pulse mid-S_SECOND, stray response right after reset
    mem[0] = 16'h8001; mem[1] = 16'h8ABC;
    do_reset0();
    mem_en0 = 1'b1;
    wait_sig0(2);
    reset_n0 = 1'b0;
    @(negedge clock);
    chk("mid_rst_req",   imem_req0, 0);
    chk("mid_rst_valid", fetch_valid0, 0);
    chk("mid_rst_out",   fetchoutput0, 0);
    chk("mid_rst_is32",  fetch_is32_0, 0);
    chk("mid_rst_pc",    fetch_pc0, 0);
    chk("mid_rst_addr",  imem_addr0, 16'h0000);
    chk("mid_rst_state", dbg_state0, S_FIRST);
    @(posedge clock); #1 reset_n0 = 1'b1;
    mem[0] = 16'h020A;
    stray0 = 1'b1;
    @(negedge clock);
    chk("stray_req", imem_req0, 0);
    @(posedge clock); #1 stray0 = 1'b0;
    @(negedge clock);
    chk("restart_req",  imem_req0, 1);
    chk("restart_addr", imem_addr0, 16'h0000);
    exp_q0.push_back({1'b0, 16'h0000, 32'h0000_020A});
    base = out_cnt0;
    wait_out0(base + 1);
    mem_en0 = 1'b0;

    // Redirect in the same cycle as a handshake (latency 0)
    lat0 = 0;
    mem[0] = 16'h020A; mem[16'h0020] = 16'h1234;
    do_reset0();
    fetch_ready0 = 1'b0;
    mem_en0 = 1'b1;
    wait_sig0(0);
    exp_q0.push_back({1'b0, 16'h0000, 32'h0000_020A});
    exp_q0.push_back({1'b0, 16'h0020, 32'h0000_1234});
    base = out_cnt0;
    fetch_ready0 = 1'b1;
    branch_valid0 = 1'b1; branch_target0 = 16'h0020;
    @(posedge clock); #1 branch_valid0 = 1'b0;
    wait_out0(base + 2);
    mem_en0 = 1'b0;
    @(negedge clock);
    chk("brhs_next_addr", imem_addr0, 16'h0021);

    // Address wrap: 32-bit instruction straddling 0xFFFF -> 0x0000
    mem[16'hFFFF] = 16'h8001; mem[0] = 16'h8002;
    exp_q1.push_back({1'b1, 16'hFFFF, 32'h8002_8001});
    @(posedge clock); #1 reset_n1 = 1'b1;
    fetch_ready1 = 1'b1;
    mem_en1 = 1'b1;
    begin
      int n = 0;
      while (out_cnt1 < 1 && n < 200) begin
        @(posedge clock); #1;
        n++;
      end
      chk("wait_out1", (out_cnt1 >= 1), 1);
    end
    mem_en1 = 1'b0;
    @(negedge clock);
    chk("wrap_next_addr", imem_addr1, 16'h0001);

    // Drain
    repeat (3) @(posedge clock);
    chk("q0_drained", exp_q0.size(), 0);
    chk("q1_drained", exp_q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
